demod_decimator: RTL and testbench

DEMOD_DECIMATOR -- requirements
Module: demod_decimator

---
 rtl/demod_decimator_pkg.sv | 25 ++
 rtl/demod_decimator_sat_trunc.sv | 29 ++
 rtl/demod_decimator.sv | 89 ++++++++
 tb/tb_demod_decimator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/demod_decimator_pkg.sv
// demod_decimator_pkg: shared FM-demod constants, output FSM states and helper functions
package demod_decimator_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_OUT_WIDTH = 16;
    localparam int SAT_MAX_DEFAULT   = 32767;
    localparam int SAT_MIN_DEFAULT   = -32768;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

    function automatic int log2c(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/demod_decimator_sat_trunc.sv
// sat_trunc: clamps a signed value into the signed OUT_W range and flags when clamping occurred
module sat_trunc
    import demod_decimator_pkg::*;
#(
    parameter int IN_W  = 40,
    parameter int OUT_W = DEFAULT_OUT_WIDTH
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);

    localparam int W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam logic signed [W-1:0] MAX = W'(sat_max(OUT_W));
    localparam logic signed [W-1:0] MIN = W'(sat_min(OUT_W));

    logic signed [W-1:0] x;
    logic over, under;

    // compare at a common width so narrow inputs never clamp
    always_comb begin
        x     = W'(in_i);
        over  = x > MAX;
        under = x < MIN;
        out_o = over ? OUT_W'(MAX) : under ? OUT_W'(MIN) : OUT_W'(x);
        sat_o = over | under;
    end

endmodule

// File: rtl/demod_decimator.sv
// demod_decimator: integrate-and-dump decimator with scaling, saturation and a one-deep output handshake
module demod_decimator
    import demod_decimator_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DECIM     = 8,
    parameter int SHIFT     = 16,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic signed [2*WIDTH-1:0]   demod_i,
    input  logic                        ready_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        valid_o,
    output logic                        sat_o,
    output logic                        overrun_o
);

    localparam int CNT_W     = log2c(DECIM);
    localparam int ACC_W     = 2 * WIDTH + CNT_W;
    localparam int SHIFT_TOT = CNT_W + SHIFT;

    logic signed [ACC_W-1:0]     acc_q, acc_d, sum, scaled;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] data_q, data_d, sat_data;
    logic                        sat_q, sat_d, sat_flag;
    logic                        overrun_q, overrun_d;
    out_state_e                  state_q, state_d;
    logic                        dump;

    assign sum    = acc_q + ACC_W'(demod_i);
    assign scaled = sum >>> SHIFT_TOT;
    assign dump   = start_i && (cnt_q == CNT_W'(DECIM - 1));

    sat_trunc #(.IN_W(ACC_W), .OUT_W(OUT_WIDTH)) u_sat_trunc (
        .in_i  (scaled),
        .out_o (sat_data),
        .sat_o (sat_flag)
    );

    // accumulate accepted samples, dump on the last of each frame, and run the output handshake
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sat_d     = sat_q;
        overrun_d = overrun_q;
        state_d   = state_q;
        if (start_i) begin
            acc_d = dump ? '0 : sum;
            cnt_d = dump ? '0 : cnt_q + CNT_W'(1);
        end
        if (dump) begin
            data_d    = sat_data;
            sat_d     = sat_flag;
            overrun_d = overrun_q | (state_q == FULL && !ready_i);
            state_d   = FULL;
        end else if (state_q == FULL && ready_i) begin
            state_d = EMPTY;
        end
    end

    // state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= EMPTY;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            sat_q     <= sat_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign data_o    = data_q;
    assign sat_o     = sat_q;
    assign valid_o   = (state_q == FULL);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_demod_decimator.sv
// tb_demod_decimator: directed and random checks of two decimator instances (SHIFT 16 and 8) against a frame-level model
module tb_demod_decimator;

    localparam int DECIM = 4;
    localparam int SHIFTS [2] = '{16, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] demod_i = '0;
    logic        ready_i = 1'b0;

    logic signed [15:0] data_a, data_b;
    logic valid_a, valid_b, sat_a, sat_b, ovr_a, ovr_b;

    int n_assert = 0;
    int n_fail = 0;

    longint frame_sum;
    int     n_acc;
    bit     exp_valid, exp_ovr;
    longint exp_data [2];
    bit     exp_sat [2];

    always #5 clk = ~clk;

    demod_decimator #(.WIDTH(16), .DECIM(DECIM), .SHIFT(16), .OUT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .demod_i(demod_i), .ready_i(ready_i),
        .data_o(data_a), .valid_o(valid_a), .sat_o(sat_a), .overrun_o(ovr_a)
    );

    demod_decimator #(.WIDTH(16), .DECIM(DECIM), .SHIFT(8), .OUT_WIDTH(16)) u_sat (
        .clk(clk), .rst(rst), .start_i(start_i), .demod_i(demod_i), .ready_i(ready_i),
        .data_o(data_b), .valid_o(valid_b), .sat_o(sat_b), .overrun_o(ovr_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        frame_sum = 0;
        n_acc     = 0;
        exp_valid = 0;
        exp_ovr   = 0;
        foreach (exp_data[i]) begin
            exp_data[i] = 0;
            exp_sat[i]  = 0;
        end
    endtask

    task automatic model_edge(input bit s, input logic [31:0] d, input bit r);
        bit dumped = 0;
        if (s) begin
            frame_sum += longint'($signed(d));
            n_acc++;
            if (n_acc == DECIM) begin
                dumped = 1;
                foreach (exp_data[i]) begin
                    longint q = frame_sum >>> ($clog2(DECIM) + SHIFTS[i]);
                    exp_sat[i]  = (q > 32767) || (q < -32768);
                    exp_data[i] = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
                end
                frame_sum = 0;
                n_acc     = 0;
            end
        end
        if (dumped) begin
            exp_ovr   = exp_ovr | (exp_valid & ~r);
            exp_valid = 1;
        end else if (exp_valid && r) begin
            exp_valid = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid_a"}, longint'(valid_a), longint'(exp_valid));
        check({tag, ".valid_b"}, longint'(valid_b), longint'(exp_valid));
        check({tag, ".ovr_a"}, longint'(ovr_a), longint'(exp_ovr));
        check({tag, ".ovr_b"}, longint'(ovr_b), longint'(exp_ovr));
        check({tag, ".data_a"}, longint'(data_a), exp_data[0]);
        check({tag, ".data_b"}, longint'(data_b), exp_data[1]);
        check({tag, ".sat_a"}, longint'(sat_a), longint'(exp_sat[0]));
        check({tag, ".sat_b"}, longint'(sat_b), longint'(exp_sat[1]));
    endtask

    task automatic step(input string tag, input bit s, input logic [31:0] d, input bit r);
        start_i = s;
        demod_i = d;
        ready_i = r;
        @(posedge clk);
        if (rst) model_edge(s, d, r);
        #1;
        check_all(tag);
    endtask

    task automatic frame(input string tag, input logic [31:0] d, input bit r);
        for (int k = 0; k < DECIM; k++) step(tag, 1'b1, d, r);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b1;

        frame("const", 32'd65536, 1'b0);
        check("const.data_is_1", longint'(data_a), 1);
        check("const.valid", longint'(valid_a), 1);
        step("consume", 1'b0, '0, 1'b1);
        step("idle", 1'b0, '0, 1'b1);

        frame("neg1", 32'hFFFF_FFFF, 1'b0);
        check("neg1.floor", longint'(data_a), -1);
        step("consume", 1'b0, '0, 1'b1);
        frame("neg64k", 32'hFFFF_0000, 1'b0);
        check("neg64k.floor", longint'(data_a), -1);
        step("consume", 1'b0, '0, 1'b1);

        frame("satpos", 32'h7FFF_FFFF, 1'b0);
        check("satpos.data", longint'(data_b), 32767);
        check("satpos.sat", longint'(sat_b), 1);
        step("consume", 1'b0, '0, 1'b1);
        frame("satneg", 32'h8000_0000, 1'b0);
        check("satneg.data", longint'(data_b), -32768);
        check("satneg.sat", longint'(sat_b), 1);
        step("consume", 1'b0, '0, 1'b1);

        frame("simul1", 32'd131072, 1'b0);
        for (int k = 0; k < DECIM - 1; k++) step("simul2", 1'b1, 32'd65536, 1'b0);
        step("simul_dump", 1'b1, 32'd65536, 1'b1);
        check("simul.no_ovr", longint'(ovr_a), 0);
        check("simul.valid", longint'(valid_a), 1);
        check("simul.data", longint'(data_a), 1);
        step("consume", 1'b0, '0, 1'b1);

        for (int k = 0; k < DECIM; k++) begin
            step("gap_s", 1'b1, 32'd65536, 1'b0);
            step("gap_i", 1'b0, 32'hDEAD_BEEF, 1'b1);
            step("gap_i", 1'b0, 32'h1234_5678, 1'b0);
        end
        check("gap.data", longint'(data_a), 1);
        step("consume", 1'b0, '0, 1'b1);

        frame("ovr1", 32'd65536, 1'b0);
        frame("ovr2", 32'd196608, 1'b0);
        check("ovr.data", longint'(data_a), 3);
        check("ovr.flag", longint'(ovr_a), 1);
        step("consume", 1'b0, '0, 1'b1);
        step("idle", 1'b0, '0, 1'b1);
        check("ovr.sticky", longint'(ovr_a), 1);

        frame("prerst", 32'd65536, 1'b0);
        step("mid", 1'b1, 32'd65536, 1'b0);
        step("mid", 1'b1, 32'd65536, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b1;
        for (int k = 0; k < DECIM - 1; k++) step("postrst", 1'b1, 32'd65536, 1'b0);
        check("postrst.no_early", longint'(valid_a), 0);
        step("postrst", 1'b1, 32'd65536, 1'b0);
        check("postrst.data", longint'(data_a), 1);
        step("consume", 1'b0, '0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] d = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed($urandom_range(0, 400000)) - 200000);
            step("rand", $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
